// File: rtl/ysyx_22050019_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// ysyx_22050019_wb_arbiter_if
//   Bundle of signals between the two writeback requesters (EXU, LSU), the
//   pipeline-redirect flush, and the MEM/WB writeback/commit fields.
//
//   master modport : the requester side (EXU/LSU/pipeline control). It drives
//                    flush, the valid flags and payloads. It observes ready,
//                    the writeback fields, commit and starve.
//   slave modport  : the arbiter side. It accepts the requests and drives
//                    ready, writeback, commit and starve.
//
//   Signals
//     flush                        discard any request offered this cycle
//     exu_valid/ready              EXU result handshake
//     exu_we/waddr/wdata/pc/inst   EXU result payload
//     lsu_valid/ready              LSU result handshake
//     lsu_we/waddr/wdata/pc/inst   LSU load-result payload
//     wb_we/waddr/wdata            register-file write port
//     wb_pc/wb_inst                committed instruction PC and encoding
//     commit                       one instruction retired this cycle
//     starve                       EXU starvation count (debug)
// ---------------------------------------------------------------------------
interface ysyx_22050019_wb_arbiter_if;
  logic        flush;

  logic        exu_valid;
  logic        exu_ready;
  logic        exu_we;
  logic [4:0]  exu_waddr;
  logic [63:0] exu_wdata;
  logic [63:0] exu_pc;
  logic [31:0] exu_inst;

  logic        lsu_valid;
  logic        lsu_ready;
  logic        lsu_we;
  logic [4:0]  lsu_waddr;
  logic [63:0] lsu_wdata;
  logic [63:0] lsu_pc;
  logic [31:0] lsu_inst;

  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [63:0] wb_wdata;
  logic [63:0] wb_pc;
  logic [31:0] wb_inst;
  logic        commit;
  logic [3:0]  starve;

  modport master (
    output flush,
    output exu_valid, exu_we, exu_waddr, exu_wdata, exu_pc, exu_inst,
    input  exu_ready,
    output lsu_valid, lsu_we, lsu_waddr, lsu_wdata, lsu_pc, lsu_inst,
    input  lsu_ready,
    input  wb_we, wb_waddr, wb_wdata, wb_pc, wb_inst, commit, starve
  );

  modport slave (
    input  flush,
    input  exu_valid, exu_we, exu_waddr, exu_wdata, exu_pc, exu_inst,
    output exu_ready,
    input  lsu_valid, lsu_we, lsu_waddr, lsu_wdata, lsu_pc, lsu_inst,
    output lsu_ready,
    output wb_we, wb_waddr, wb_wdata, wb_pc, wb_inst, commit, starve
  );
endinterface

// File: rtl/ysyx_22050019_wb_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22050019_wb_arbiter
//   Arbitrates the single register-file write / commit port between the EXU
//   result path and the LSU load-result path. The LSU has fixed priority. An
//   EXU request that has been blocked STARVE_MAX consecutive cycles is forced
//   through, so the EXU is granted within STARVE_MAX+1 cycles. The granted
//   request is registered onto the writeback port one cycle after acceptance.
//
//   Parameters
//     STARVE_MAX   EXU-blocked cycles before the EXU wins (legal range 1..15)
//
//   Ports
//     clk          clock, rising edge
//     rst_n        asynchronous active-low reset
//     bus          slave side of ysyx_22050019_wb_arbiter_if
//                  (requests in; ready, writeback, commit and starve out)
// ---------------------------------------------------------------------------
module ysyx_22050019_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ysyx_22050019_wb_arbiter_if.slave     bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // Registered writeback state
  logic        wb_we_reg;
  logic [4:0]  wb_waddr_reg;
  logic [63:0] wb_wdata_reg;
  logic [63:0] wb_pc_reg;
  logic [31:0] wb_inst_reg;
  logic        commit_reg;
  logic [3:0]  starve_cnt_reg;

  // Grant decode
  logic        force_exu;
  logic        g_lsu;
  logic        g_exu;
  logic        grant;

  // Selected payload
  logic        sel_we;
  logic [4:0]  sel_waddr;
  logic [63:0] sel_wdata;
  logic [63:0] sel_pc;
  logic [31:0] sel_inst;

  logic [3:0]  starve_cnt_next;

  // The EXU is forced through only while it is still offering. A forced EXU
  // takes precedence over the LSU even if the LSU is valid.
  // The grants are also gated by rst_n. This keeps both ready outputs at 0
  // while reset is held, so a requester cannot see its offer consumed while
  // the writeback register is forced to 0.
  always_comb begin
    force_exu = bus.exu_valid & (starve_cnt_reg == STARVE_LIM);
    g_lsu     = rst_n & ~bus.flush & bus.lsu_valid & ~force_exu;
    g_exu     = rst_n & ~bus.flush & bus.exu_valid & ~g_lsu;
    grant     = g_lsu | g_exu;
  end

  // A flushed offer is still acknowledged, so the producer retires it. It
  // never reaches the writeback register.
  assign bus.lsu_ready = g_lsu | (rst_n & bus.flush & bus.lsu_valid);
  assign bus.exu_ready = g_exu | (rst_n & bus.flush & bus.exu_valid);

  always_comb begin
    sel_we    = bus.exu_we;
    sel_waddr = bus.exu_waddr;
    sel_wdata = bus.exu_wdata;
    sel_pc    = bus.exu_pc;
    sel_inst  = bus.exu_inst;
    if (g_lsu) begin
      sel_we    = bus.lsu_we;
      sel_waddr = bus.lsu_waddr;
      sel_wdata = bus.lsu_wdata;
      sel_pc    = bus.lsu_pc;
      sel_inst  = bus.lsu_inst;
    end
  end

  // The starvation counter clears when the EXU is served or stops asking. It
  // counts only cycles where the LSU actually took the port from a waiting
  // EXU. It holds across flush cycles, so a redirect does not reset fairness.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (g_exu || !bus.exu_valid) begin
      starve_cnt_next = 4'd0;
    end else if (g_lsu) begin
      if (starve_cnt_reg != STARVE_LIM) begin
        starve_cnt_next = starve_cnt_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_reg      <= 1'b0;
      wb_waddr_reg   <= 5'd0;
      wb_wdata_reg   <= 64'd0;
      wb_pc_reg      <= 64'd0;
      wb_inst_reg    <= 32'd0;
      commit_reg     <= 1'b0;
      starve_cnt_reg <= 4'd0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      if (grant) begin
        // A write to x0 still retires the instruction. Only the
        // register-file write is suppressed.
        wb_we_reg    <= sel_we & (sel_waddr != 5'd0);
        wb_waddr_reg <= sel_waddr;
        wb_wdata_reg <= sel_wdata;
        wb_pc_reg    <= sel_pc;
        wb_inst_reg  <= sel_inst;
        commit_reg   <= 1'b1;
      end else begin
        // The payload fields hold, so the debug view keeps the last retired
        // instruction.
        wb_we_reg    <= 1'b0;
        commit_reg   <= 1'b0;
      end
    end
  end

  assign bus.wb_we    = wb_we_reg;
  assign bus.wb_waddr = wb_waddr_reg;
  assign bus.wb_wdata = wb_wdata_reg;
  assign bus.wb_pc    = wb_pc_reg;
  assign bus.wb_inst  = wb_inst_reg;
  assign bus.commit   = commit_reg;
  assign bus.starve   = starve_cnt_reg;

endmodule

// File: tb/tb_ysyx_22050019_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050019_wb_arbiter
//   Self-checking bench for the writeback arbiter. Each granted request is
//   pushed as an expected commit record. It is popped and compared when the
//   writeback port shows its commit. The grant/ready/starve model follows
//   the arbitration equations directly.
// ---------------------------------------------------------------------------
module tb_ysyx_22050019_wb_arbiter;
  localparam int STARVE_MAX = 4;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic [31:0] inst;
  } wb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050019_wb_arbiter_if bus ();

  ysyx_22050019_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  wb_t  sb[$];
  wb_t  last_wb;
  int   m_starve;
  logic lsu_acc, exu_acc;
  logic exu_got;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_exu(input logic v, input logic we, input logic [4:0] a,
                         input logic [63:0] d, input logic [63:0] pc, input logic [31:0] inst);
    bus.exu_valid = v; bus.exu_we = we; bus.exu_waddr = a;
    bus.exu_wdata = d; bus.exu_pc = pc; bus.exu_inst = inst;
  endtask

  task automatic set_lsu(input logic v, input logic we, input logic [4:0] a,
                         input logic [63:0] d, input logic [63:0] pc, input logic [31:0] inst);
    bus.lsu_valid = v; bus.lsu_we = we; bus.lsu_waddr = a;
    bus.lsu_wdata = d; bus.lsu_pc = pc; bus.lsu_inst = inst;
  endtask

  // One clock cycle with the inputs currently driven: check ready, predict,
  // advance the clock, and compare the writeback port.
  task automatic step(input string tag);
    logic fx, gl, ge;
    wb_t  e;
    wb_t  got;
    #1;
    fx = bus.exu_valid && (m_starve == STARVE_MAX);
    gl = !bus.flush && bus.lsu_valid && !fx;
    ge = !bus.flush && bus.exu_valid && !gl;
    check_val({tag, ".lsu_ready"}, 64'(bus.lsu_ready), 64'(gl | (bus.flush & bus.lsu_valid)));
    check_val({tag, ".exu_ready"}, 64'(bus.exu_ready), 64'(ge | (bus.flush & bus.exu_valid)));
    lsu_acc = gl | (bus.flush & bus.lsu_valid);
    exu_acc = ge | (bus.flush & bus.exu_valid);
    exu_got = ge;
    if (gl) sb.push_back('{bus.lsu_we && bus.lsu_waddr != 0, bus.lsu_waddr, bus.lsu_wdata, bus.lsu_pc, bus.lsu_inst});
    else if (ge) sb.push_back('{bus.exu_we && bus.exu_waddr != 0, bus.exu_waddr, bus.exu_wdata, bus.exu_pc, bus.exu_inst});
    if (ge || !bus.exu_valid) m_starve = 0;
    else if (gl && m_starve != STARVE_MAX) m_starve++;
    @(posedge clk);
    #1;
    check_val({tag, ".starve"}, 64'(bus.starve), 64'(m_starve));
    got = '{bus.wb_we, bus.wb_waddr, bus.wb_wdata, bus.wb_pc, bus.wb_inst};
    if (gl || ge) begin
      e = sb.pop_front();
      check_val({tag, ".commit"}, 64'(bus.commit), 64'd1);
      check_val({tag, ".wb_we"}, 64'(got.we), 64'(e.we));
      check_val({tag, ".wb_waddr"}, 64'(got.waddr), 64'(e.waddr));
      check_val({tag, ".wb_wdata"}, got.wdata, e.wdata);
      check_val({tag, ".wb_pc"}, got.pc, e.pc);
      check_val({tag, ".wb_inst"}, 64'(got.inst), 64'(e.inst));
      last_wb = e;
    end else begin
      check_val({tag, ".commit"}, 64'(bus.commit), 64'd0);
      check_val({tag, ".wb_we"}, 64'(got.we), 64'd0);
      check_val({tag, ".wb_pc_hold"}, got.pc, last_wb.pc);
      check_val({tag, ".wb_wdata_hold"}, got.wdata, last_wb.wdata);
    end
    $display("[%0t] %s lsu_v=%0b exu_v=%0b flush=%0b commit=%0b pc=0x%0h starve=%0d",
             $time, tag, bus.lsu_valid, bus.exu_valid, bus.flush, bus.commit, bus.wb_pc, bus.starve);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".commit"}, 64'(bus.commit), 64'd0);
    check_val({tag, ".wb_we"}, 64'(bus.wb_we), 64'd0);
    check_val({tag, ".wb_waddr"}, 64'(bus.wb_waddr), 64'd0);
    check_val({tag, ".wb_wdata"}, bus.wb_wdata, 64'd0);
    check_val({tag, ".wb_pc"}, bus.wb_pc, 64'd0);
    check_val({tag, ".wb_inst"}, 64'(bus.wb_inst), 64'd0);
    check_val({tag, ".starve"}, 64'(bus.starve), 64'd0);
    check_val({tag, ".lsu_ready"}, 64'(bus.lsu_ready), 64'd0);
    check_val({tag, ".exu_ready"}, 64'(bus.exu_ready), 64'd0);
  endtask

  task automatic model_reset();
    sb.delete();
    last_wb  = '0;
    m_starve = 0;
  endtask

  initial begin
    int exp_starve [5];
    int commits_p;
    exp_starve = '{1, 2, 3, 4, 0};
    bus.flush = 1'b0;
    set_exu(1'b1, 1'b1, 5'd3, 64'h11, 64'h100, 32'h13);
    set_lsu(1'b1, 1'b1, 5'd4, 64'h22, 64'h200, 32'h3);
    model_reset();

    // Power-on reset: outputs must be 0 even with both requesters valid.
    #12;
    check_reset_outputs("por");
    set_exu(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0);
    set_lsu(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    step("idle");

    // EXU alone
    set_exu(1'b1, 1'b1, 5'd5, 64'h1234, 64'h8000_0000, 32'h0050_0293);
    step("exu_alone");
    set_exu(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0);

    // LSU write to x0: commits without writing
    set_lsu(1'b1, 1'b1, 5'd0, 64'hdead, 64'h8000_0004, 32'h0000_3003);
    step("x0_write");
    set_lsu(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0);
    step("idle2");

    // Contention: both valid continuously. The LSU wins 4 times and the EXU
    // wins on the 5th cycle.
    set_exu(1'b1, 1'b1, 5'd7, 64'hE0E0, 64'h8000_1000, 32'h0070_0393);
    for (int i = 0; i < 5; i++) begin
      set_lsu(1'b1, 1'b1, 5'(8 + i), 64'(64'hA000 + i), 64'(64'h8000_2000 + 4 * i), 32'h0000_3083);
      step($sformatf("contend%0d", i));
      check_val($sformatf("contend%0d.starve_seq", i), 64'(bus.starve), 64'(exp_starve[i]));
      check_val($sformatf("contend%0d.exu_won", i), 64'(exu_got), 64'(i == 4));
    end
    set_exu(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0);
    set_lsu(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0);
    step("idle3");

    // Flush with a non-zero starve count: both offers are dropped and the
    // count holds.
    set_exu(1'b1, 1'b1, 5'd9, 64'h99, 64'h8000_3000, 32'h13);
    set_lsu(1'b1, 1'b1, 5'd10, 64'hAA, 64'h8000_3100, 32'h3);
    step("pre_flush0");
    set_lsu(1'b1, 1'b1, 5'd11, 64'hAB, 64'h8000_3104, 32'h3);
    step("pre_flush1");
    bus.flush = 1'b1;
    set_lsu(1'b1, 1'b1, 5'd12, 64'hAC, 64'h8000_3108, 32'h3);
    step("flush");
    check_val("flush.starve_held", 64'(bus.starve), 64'd2);
    bus.flush = 1'b0;

    // Stall hold: the EXU is blocked while the LSU has work. The LSU then
    // drops valid, and the EXU payload must commit exactly once.
    set_exu(1'b1, 1'b1, 5'd14, 64'h5151_5151, 64'h8000_4000, 32'h00E0_0713);
    set_lsu(1'b1, 1'b1, 5'd15, 64'h77, 64'h8000_4100, 32'h3);
    step("stall0");
    set_lsu(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0);
    commits_p = 0;
    for (int i = 0; i < 4; i++) begin
      step($sformatf("stall%0d", i + 1));
      if (bus.commit && bus.wb_pc == 64'h8000_4000) commits_p++;
      if (exu_acc) set_exu(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0);
    end
    check_val("stall.commit_once", 64'(commits_p), 64'd1);

    // Reset mid-transfer: assert between edges while commit is high.
    set_exu(1'b1, 1'b1, 5'd1, 64'h111, 64'h8000_5000, 32'h13);
    set_lsu(1'b1, 1'b1, 5'd2, 64'h222, 64'h8000_5100, 32'h3);
    step("pre_rst0");
    set_lsu(1'b1, 1'b1, 5'd3, 64'h333, 64'h8000_5104, 32'h3);
    step("pre_rst1");
    check_val("pre_rst.commit", 64'(bus.commit), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    check_reset_outputs("mid_rst_edge");
    rst_n = 1'b1;
    model_reset();
    set_lsu(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0);
    set_exu(1'b1, 1'b1, 5'd6, 64'h6666, 64'h8000_6000, 32'h0060_0313);
    step("post_rst");
    set_exu(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0);

    // Random traffic. A payload stays stable until it is accepted.
    for (int i = 0; i < 300; i++) begin
      if (!bus.lsu_valid || lsu_acc)
        set_lsu($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), {$urandom, $urandom},
                {32'h8000_0000, $urandom}, $urandom);
      if (!bus.exu_valid || exu_acc)
        set_exu($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), {$urandom, $urandom},
                {32'h9000_0000, $urandom}, $urandom);
      bus.flush = ($urandom_range(0, 7) == 0);
      lsu_acc = 1'b0;
      exu_acc = 1'b0;
      step($sformatf("rnd%0d", i));
    end
    bus.flush = 1'b0;
    check_val("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
